// File: rtl/reg_writeback_ctrl.sv
// Register-file write-back controller: round-robin ALU/load arbitration into a
// small FIFO, one registered write per cycle, and newest-value forwarding.
module reg_writeback_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              rf_busy,
    output logic              WE,
    output logic [ADDR_W-1:0] WrReg,
    output logic [DATA_W-1:0] InData,
    input  logic [ADDR_W-1:0] fwd_reg,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [ADDR_W-1:0] count,
    output logic              empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic SIDE_ALU = 1'b0;
    localparam logic SIDE_MEM = 1'b1;

    logic [ADDR_W-1:0] fifo_reg_q  [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              side_q, side_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              full;
    logic              grant_alu;
    logic              grant_mem;
    logic              push_alu;
    logic              push_mem;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_reg;
    logic [DATA_W-1:0] push_data;

    // Arbitration: the preferred side wins only when both sources are valid.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign grant_mem = mem_valid && (!alu_valid || (side_q == SIDE_MEM));
    assign grant_alu = alu_valid && (!mem_valid || (side_q == SIDE_ALU));
    assign alu_ready = !full && !rst && grant_alu;
    assign mem_ready = !full && !rst && grant_mem;
    assign push_alu  = alu_valid && alu_ready;
    assign push_mem  = mem_valid && mem_ready;
    assign push      = push_alu || push_mem;
    assign push_reg  = push_mem ? mem_reg  : alu_reg;
    assign push_data = push_mem ? mem_data : alu_data;
    assign pop       = (count_q != '0) && !rf_busy;

    assign WE     = we_q;
    assign WrReg  = wr_reg_q;
    assign InData = wr_data_q;
    assign count  = ADDR_W'(count_q);
    assign empty  = (count_q == '0);

    always_comb begin : next_state
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        side_d    = side_q;
        we_d      = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d    = head_q + PTR_W'(1);
            we_d      = 1'b1;
            wr_reg_d  = fifo_reg_q[head_q];
            wr_data_d = fifo_data_q[head_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Preference moves away only once the preferred side has been served.
        if ((side_q == SIDE_MEM && push_mem) || (side_q == SIDE_ALU && push_alu)) begin
            side_d = ~side_q;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            side_q    <= SIDE_MEM;
            we_q      <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            side_q    <= side_d;
            we_q      <= we_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_reg_q[tail_q]  <= push_reg;
            fifo_data_q[tail_q] <= push_data;
        end
    end

    // Forwarding: scan oldest to newest so the youngest match overrides.
    always_comb begin : forward
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        if (we_q && (wr_reg_q == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data_q;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_reg_q[idx] == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[idx];
            end
        end
    end

endmodule
